// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 requester and its wait-state timer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic [31:0] BASE_ADDR = 32'hA200_0000;

   // Bit positions inside pprot
   localparam int unsigned PROT_PRIV   = 0;
   localparam int unsigned PROT_SECURE = 1;
   localparam int unsigned PROT_INSTR  = 2;

   // Counter width able to hold 0..limit; a disabled limit still needs one bit
   function automatic int unsigned timer_width(input int unsigned limit);
      return (limit == 0) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase; flags the cycle that reaches the limit.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int unsigned CNT_W   = timer_width(LIMIT);
   localparam bit          TMO_EN  = (LIMIT != 0);
   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] LAST_V  = TMO_EN ? CNT_W'(LIMIT - 1) : '0;

   logic [CNT_W-1:0] r_count;
   logic             w_at_limit;

   assign w_at_limit = (r_count == LIMIT_V);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_at_limit) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Expire on the stalled cycle that would bring the count up to the limit
   assign o_expire = TMO_EN && i_enable && (r_count == LAST_V);

endmodule

// File: rtl/apb_master.sv
// APB4 requester: one command at a time through SETUP/ACCESS, one-cycle response strobe,
// wait-state timeout abort.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DATA_STRB      = DATA_WIDTH / 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [DATA_STRB-1:0]  cmd_strb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_STRB-1:0]  pstrb,
   output logic [2:0]            pprot,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr
);

   apb_state_e            r_state;
   logic                  r_cmd_ready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_rsp_timeout;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [DATA_STRB-1:0]  r_pstrb;
   logic [2:0]            r_pprot;

   logic w_accept;
   logic w_tmr_clear;
   logic w_tmr_enable;
   logic w_expire;

   // r_cmd_ready is only ever high in IDLE, so it doubles as the state qualifier
   assign w_accept     = cmd_valid && r_cmd_ready;
   assign w_tmr_clear  = (r_state == SETUP);
   assign w_tmr_enable = (r_state == ACCESS) && !pready;

   apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk      (clk),
      .nrst     (nrst),
      .i_clear  (w_tmr_clear),
      .i_enable (w_tmr_enable),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state       <= IDLE;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_pstrb       <= '0;
         r_pprot       <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_paddr     <= cmd_addr;
                  r_pwrite    <= cmd_write;
                  r_pwdata    <= cmd_write ? cmd_wdata : '0;
                  r_pstrb     <= cmd_write ? cmd_strb : '0;
                  r_pprot     <= cmd_prot;
                  r_psel      <= 1'b1;
                  r_penable   <= 1'b0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               // pready takes priority over an expiring timer on the same cycle
               if (pready) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                  r_rsp_err     <= pslverr;
                  r_rsp_timeout <= 1'b0;
                  r_cmd_ready   <= 1'b1;
                  r_state       <= IDLE;
               end else if (w_expire) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_cmd_ready   <= 1'b1;
                  r_state       <= IDLE;
               end
            end
            default: begin
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_cmd_ready <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign pstrb       = r_pstrb;
   assign pprot       = r_pprot;

endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized transfers against a word-array memory model of the APB window.
module tb_apb_master;
   import apb_pkg::*;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_strb = '0;
   logic [2:0]  cmd_prot = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready = 1'b0;
   logic [31:0] prdata = '0;
   logic        pslverr = 1'b0;

   int checks = 0;
   int failures = 0;

   // Expected contents of the register window, updated from command fields
   logic [31:0] ref_mem [16];
   // Slave-side storage, updated only from what appears on the APB bus
   logic [31:0] slv_mem [16];

   apb_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .DATA_STRB      (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pprot       (pprot),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("cmd_ready_wait", cmd_ready, 1'b1);
   endtask

   // One complete transfer; the slave stalls 'waits' ACCESS cycles, waits >= TMO never answers
   task automatic xfer(input logic wr, input logic [3:0] idx, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input logic err);
      logic [31:0] addr;
      logic [31:0] exp_pwdata;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_pstrb;
      logic        tmo;
      logic        hit;
      addr       = BASE_ADDR + {26'd0, idx, 2'b00};
      tmo        = (waits >= TMO);
      exp_pwdata = wr ? wdata : 32'd0;
      exp_pstrb  = wr ? strb : 4'd0;
      exp_rdata  = (wr || tmo) ? 32'd0 : ref_mem[idx];
      if (wr && !tmo && !err) ref_mem[idx] = merge(ref_mem[idx], wdata, strb);

      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      cmd_prot  = prot;
      @(posedge clk);
      @(negedge clk);
      // Scramble command inputs: the bus must hold the accepted values
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom);
      cmd_prot  = 3'($urandom);
      chk1("setup_psel", psel, 1'b1);
      chk1("setup_penable", penable, 1'b0);
      chk1("setup_cmd_ready", cmd_ready, 1'b0);
      chk1("setup_rsp_valid", rsp_valid, 1'b0);
      chk("setup_paddr", paddr, addr);
      chk1("setup_pwrite", pwrite, wr);
      chk("setup_pwdata", pwdata, exp_pwdata);
      chk("setup_pstrb", {28'd0, pstrb}, {28'd0, exp_pstrb});
      chk("setup_pprot", {29'd0, pprot}, {29'd0, prot});
      @(posedge clk);

      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         chk1("access_psel", psel, 1'b1);
         chk1("access_penable", penable, 1'b1);
         chk1("access_rsp_valid", rsp_valid, 1'b0);
         chk("access_paddr", paddr, addr);
         chk("access_pwdata", pwdata, exp_pwdata);
         hit     = (k == waits);
         pready  = hit;
         pslverr = hit ? err : 1'($urandom);
         prdata  = (hit && !pwrite) ? slv_mem[paddr[5:2]] : $urandom;
         if (hit && pwrite && !err) slv_mem[paddr[5:2]] = merge(slv_mem[paddr[5:2]], pwdata, pstrb);
         @(posedge clk);
         if (hit) break;
      end

      @(negedge clk);
      cmd_valid = 1'b0;
      pready    = 1'b0;
      pslverr   = 1'($urandom);
      prdata    = $urandom;
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk1("rsp_err", rsp_err, tmo | err);
      chk1("rsp_timeout", rsp_timeout, tmo);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk1("done_psel", psel, 1'b0);
      chk1("done_penable", penable, 1'b0);
      chk1("done_cmd_ready", cmd_ready, 1'b1);
      @(negedge clk);
      chk1("rsp_single_pulse", rsp_valid, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         slv_mem[i] = ref_mem[i];
      end

      // Reset state
      #12;
      chk1("rst_cmd_ready", cmd_ready, 1'b0);
      chk1("rst_psel", psel, 1'b0);
      chk1("rst_penable", penable, 1'b0);
      chk1("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_pstrb_pprot", {25'd0, pstrb, pprot}, 32'd0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // Directed transfers
      xfer(1'b1, 4'd1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0);
      xfer(1'b0, 4'd1, 32'd0, 4'h0, 3'd0, 0, 1'b0);
      chk("readback_deadbeef", ref_mem[1], 32'hDEAD_BEEF);
      xfer(1'b1, 4'd2, 32'h1234_5678, 4'hF, 3'b001, 3, 1'b0);
      xfer(1'b0, 4'd2, 32'd0, 4'h0, 3'b010, 3, 1'b0);
      xfer(1'b0, 4'd1, 32'd0, 4'h0, 3'd0, 0, 1'b1);
      xfer(1'b1, 4'd3, 32'h0BAD_F00D, 4'hF, 3'd0, 0, 1'b1);
      xfer(1'b0, 4'd3, 32'd0, 4'h0, 3'd0, 1, 1'b0);
      xfer(1'b0, 4'd4, 32'd0, 4'h0, 3'b100, 20, 1'b0);
      xfer(1'b1, 4'd4, 32'hFFFF_FFFF, 4'hF, 3'd0, TMO, 1'b0);
      xfer(1'b0, 4'd5, 32'd0, 4'h0, 3'd0, TMO - 1, 1'b0);
      xfer(1'b1, 4'd6, 32'hAABB_CCDD, 4'b0101, 3'b111, 0, 1'b0);
      xfer(1'b0, 4'd6, 32'd0, 4'h0, 3'd0, 2, 1'b0);

      // Reset asserted during ACCESS
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = BASE_ADDR + 32'd8;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk1("mid_rst_in_access", penable, 1'b1);
      nrst = 1'b0;
      #1;
      chk1("mid_rst_psel", psel, 1'b0);
      chk1("mid_rst_penable", penable, 1'b0);
      chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      xfer(1'b0, 4'd2, 32'd0, 4'h0, 3'd0, 0, 1'b0);

      // Randomized transfers
      for (int n = 0; n < 40; n++) begin
         int w;
         w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 2, TMO + 2))
                                         : int'($urandom_range(0, 3));
         xfer(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 3'($urandom), w,
              ($urandom_range(0, 4) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
